// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: RAW stall detection, bubble injection, taken-branch flush.
// Define HAZARD_FORWARD_EN when a forwarding unit is present (only load-use then stalls).
//
// state | meaning
// RUN   | detection active; a hazard stalls this cycle
// STALL | continuing a multi-cycle stall; detection suspended
module hazard_ctrl #(
    parameter int REG_W  = 5,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic              id_uses_rt,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic [REG_W-1:0]  ex_wreg,
    input  logic              mem_regwrite,
    input  logic [REG_W-1:0]  mem_wreg,
    input  logic              branch_taken,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              exmem_flush,
    output logic [STAT_W-1:0] stall_cycles,
    output logic [STAT_W-1:0] flush_count
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] stall_left;
    logic [1:0] n_stall;
    logic       match_ex;
    logic       stall_now;
    logic       unused_inputs;

    assign match_ex = id_valid && (ex_wreg != '0) &&
                      ((ex_wreg == id_rs) || (id_uses_rt && (ex_wreg == id_rt)));

`ifdef HAZARD_FORWARD_EN
    // EX/MEM results are forwarded, so only a load in EX can still hazard.
    assign unused_inputs = ^{mem_regwrite, mem_wreg};

    always_comb begin
        n_stall = 2'd0;
        if (ex_memread && ex_regwrite && match_ex)
            n_stall = 2'd1;
    end
`else
    logic match_mem;

    assign unused_inputs = ex_memread;
    assign match_mem = id_valid && (mem_wreg != '0) &&
                       ((mem_wreg == id_rs) || (id_uses_rt && (mem_wreg == id_rt)));

    always_comb begin
        n_stall = 2'd0;
        if (ex_regwrite && match_ex)
            n_stall = 2'd2;
        else if (mem_regwrite && match_mem)
            n_stall = 2'd1;
    end
`endif

    assign stall_now = !rst && !branch_taken &&
                       ((state == STALL) || (n_stall != 2'd0));

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_flush = 1'b0;
        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
        end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
        end else if (stall_now) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            stall_left   <= 2'd0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (branch_taken) begin
                state      <= RUN;
                stall_left <= 2'd0;
            end else if (state == RUN) begin
                // The current cycle is already the first stall cycle.
                if (n_stall == 2'd2) begin
                    state      <= STALL;
                    stall_left <= 2'd1;
                end
            end else begin
                if (stall_left <= 2'd1) begin
                    state      <= RUN;
                    stall_left <= 2'd0;
                end else begin
                    stall_left <= stall_left - 2'd1;
                end
            end

            if (stall_now && (stall_cycles != '1))
                stall_cycles <= stall_cycles + STAT_W'(1);
            if (branch_taken && (flush_count != '1))
                flush_count <= flush_count + STAT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed bench for hazard_ctrl against a stall-budget reference model.
// A second instance with 2-bit statistics exercises counter saturation.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       ex_regwrite;
    logic       ex_memread;
    logic [4:0] ex_wreg;
    logic       mem_regwrite;
    logic [4:0] mem_wreg;
    logic       branch_taken;

    logic        pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush;
    logic [15:0] stall_cycles, flush_count;
    logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble, s_exmem_flush;
    logic [1:0]  s_stall_cycles, s_flush_count;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // reference model: remaining stall cycles owed plus saturating statistics
    int busy;
    int m_stall, m_flush, m_stall_s, m_flush_s;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_W(5), .STAT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_wreg(ex_wreg), .mem_regwrite(mem_regwrite), .mem_wreg(mem_wreg),
        .branch_taken(branch_taken), .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .exmem_flush(exmem_flush),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    hazard_ctrl #(.REG_W(5), .STAT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_wreg(ex_wreg), .mem_regwrite(mem_regwrite), .mem_wreg(mem_wreg),
        .branch_taken(branch_taken), .pc_write(s_pc_write), .ifid_write(s_ifid_write),
        .ifid_flush(s_ifid_flush), .idex_bubble(s_idex_bubble), .exmem_flush(s_exmem_flush),
        .stall_cycles(s_stall_cycles), .flush_count(s_flush_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    endtask

    function automatic bit m(input logic [4:0] r);
        return id_valid && r != 0 && (r == id_rs || (id_uses_rt && r == id_rt));
    endfunction

    function automatic int stall_len();
`ifdef HAZARD_FORWARD_EN
        if (ex_memread && ex_regwrite && m(ex_wreg)) return 1;
        return 0;
`else
        if (ex_regwrite && m(ex_wreg)) return 2;
        if (mem_regwrite && m(mem_wreg)) return 1;
        return 0;
`endif
    endfunction

    task automatic set_in(input bit r, input bit br, input bit v, input int rs, input int rt,
                          input bit ut, input bit ew, input bit em, input int er,
                          input bit mw, input int mr);
        rst = r; branch_taken = br; id_valid = v;
        id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rt = ut;
        ex_regwrite = ew; ex_memread = em; ex_wreg = 5'(er);
        mem_regwrite = mw; mem_wreg = 5'(mr);
    endtask

    task automatic step();
        bit e_pc, e_ifw, e_iff, e_bub, e_exf;
        int nb, n;
        #1;
        nb = busy;
        if (rst) begin
            {e_pc, e_ifw, e_iff, e_bub, e_exf} = 5'b00111;
        end else if (branch_taken) begin
            {e_pc, e_ifw, e_iff, e_bub, e_exf} = 5'b11111;
        end else begin
            n = (busy > 0) ? 0 : stall_len();
            if (busy > 0 || n > 0) begin
                {e_pc, e_ifw, e_iff, e_bub, e_exf} = 5'b00010;
                nb = (busy > 0) ? busy - 1 : n - 1;
            end else begin
                {e_pc, e_ifw, e_iff, e_bub, e_exf} = 5'b11000;
            end
        end
        chk("pc_write", 32'(pc_write), 32'(e_pc));
        chk("ifid_write", 32'(ifid_write), 32'(e_ifw));
        chk("ifid_flush", 32'(ifid_flush), 32'(e_iff));
        chk("idex_bubble", 32'(idex_bubble), 32'(e_bub));
        chk("exmem_flush", 32'(exmem_flush), 32'(e_exf));
        chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
        chk("flush_count", 32'(flush_count), 32'(m_flush));
        chk("sat_stall_cycles", 32'(s_stall_cycles), 32'(m_stall_s));
        chk("sat_flush_count", 32'(s_flush_count), 32'(m_flush_s));
        @(posedge clk);
        if (rst) begin
            busy = 0; m_stall = 0; m_flush = 0; m_stall_s = 0; m_flush_s = 0;
        end else begin
            busy = branch_taken ? 0 : nb;
            if (branch_taken) begin
                if (m_flush < 65535) m_flush++;
                if (m_flush_s < 3) m_flush_s++;
            end else if (!e_pc) begin
                if (m_stall < 65535) m_stall++;
                if (m_stall_s < 3) m_stall_s++;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle();
        set_in(0, 0, 1, 1, 2, 1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        busy = 0; m_stall = 0; m_flush = 0; m_stall_s = 0; m_flush_s = 0;
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        repeat (3) step();
        idle(); step();

        // load-use: rs matches loading destination
        set_in(0, 0, 1, 8, 3, 0, 1, 1, 8, 0, 0); step();
        idle(); step(); step();
        // destination r0 never matches
        set_in(0, 0, 1, 0, 3, 0, 1, 1, 0, 0, 0); step();
        idle(); step();
        // ALU producer in EX matches rt
        set_in(0, 0, 1, 4, 9, 1, 1, 0, 9, 0, 0); step(); step();
        idle(); step(); step();
        // rt not read: no hazard
        set_in(0, 0, 1, 4, 9, 0, 1, 0, 9, 0, 0); step();
        idle(); step();
        // producer in MEM only
        set_in(0, 0, 1, 9, 5, 0, 0, 0, 0, 1, 9); step();
        idle(); step(); step();
        // branch arrives during the stall
        set_in(0, 0, 1, 4, 9, 1, 1, 0, 9, 0, 0); step();
        set_in(0, 1, 1, 4, 9, 1, 1, 0, 9, 0, 0); step();
        idle(); step(); step();
        // branch together with a fresh hazard
        set_in(0, 1, 1, 7, 3, 0, 1, 1, 7, 1, 7); step();
        idle(); step();
        // reset mid-stall
        set_in(0, 0, 1, 4, 9, 1, 1, 0, 9, 0, 0); step();
        set_in(1, 0, 1, 4, 9, 1, 1, 0, 9, 0, 0); step();
        idle(); step(); step();
        // invalid ID slot never stalls
        set_in(0, 0, 0, 8, 8, 1, 1, 1, 8, 1, 8); step();
        // repeated load-use hazards drive the 2-bit counter into saturation
        repeat (5) begin
            set_in(0, 0, 1, 8, 3, 0, 1, 1, 8, 0, 0); step();
            idle(); step(); step();
        end

        for (int i = 0; i < 1500; i++) begin
            set_in($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
                   $urandom_range(0, 4) != 0,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   1'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom),
                   int'($urandom_range(0, 3)));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage datapath. It compares the ID-stage source registers against destinations held in the ID/EX and EX/MEM registers and holds PC and IF/ID on a read-after-write hazard. It injects bubbles into ID/EX by zeroing its WB/M/EX control fields, and flushes the wrong-path instructions when a branch resolves taken in MEM. A small state machine sequences multi-cycle stalls so that detection is not re-run while a stall is in progress.

## Interface
Parameters:
- REG_W, 5, register-specifier width
- STAT_W, 16, width of the stall/flush statistics counters

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  IF/ID holds a real instruction (not a bubble)
- id_rs  in  REG_W  ID-stage rs
- id_rt  in  REG_W  ID-stage rt
- id_uses_rt  in  1  instruction reads rt (R-type, store, branch)
- ex_regwrite  in  1  RegWrite bit of the ID/EX WB field
- ex_memread  in  1  MemRead bit of the ID/EX M field
- ex_wreg  in  REG_W  ID/EX destination after the RegDst mux
- mem_regwrite  in  1  RegWrite in EX/MEM
- mem_wreg  in  REG_W  EX/MEM destination
- branch_taken  in  1  branch resolved taken in MEM this cycle
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID loads a bubble
- idex_bubble  out  1  ID/EX loads zero WB/M/EX control
- exmem_flush  out  1  EX/MEM loads zero control
- stall_cycles  out  STAT_W  total stall cycles since reset
- flush_count  out  STAT_W  total taken-branch flushes since reset

## Operation
- States: RUN, STALL. The state register and `stall_left` (2 bits) are the only control state. Outputs are decoded combinationally from state, `rst` and the inputs.
- Match condition: `m(r) = id_valid && r != 0 && (r == id_rs || (id_uses_rt && r == id_rt))`. Register 0 never matches.
- Stall length N, evaluated only in RUN:
  - See Configuration for the rules that set N.
  - N = 0 means no hazard.
- Stall outputs: `pc_write=0`, `ifid_write=0`, `idex_bubble=1`, `ifid_flush=0`, `exmem_flush=0`.
- Normal outputs: `pc_write=1`, `ifid_write=1`, all flush and bubble outputs 0.
- RUN:
  - N = 0: normal outputs.
  - N ≥ 1: this cycle is the first stall cycle.
  - N = 2: next state is STALL with `stall_left=1`.
- STALL: drives stall outputs; decrements `stall_left`; returns to RUN when it reaches 0. No detection runs in STALL.
- Branch taken (any state): `ifid_flush=1`, `idex_bubble=1`, `exmem_flush=1`, `pc_write=1`, `ifid_write=1`; next state RUN with `stall_left=0`.
  - Branch takes priority over any detected hazard or pending stall.
- Statistics:
  - `stall_cycles` increments by 1 in every cycle that drives stall outputs.
  - `flush_count` increments by 1 in every cycle with `branch_taken`.
  - Both saturate at all-ones; they never wrap.

## Timing
- While `rst=1`: state RUN, `stall_left=0`, counters 0; `pc_write=0`, `ifid_write=0`, `ifid_flush=1`, `idex_bubble=1`, `exmem_flush=1`.
- First cycle after `rst` falls: normal outputs unless a hazard or branch is present.
- Hazard-to-stall latency is 0 cycles: combinational in the same cycle as the match.
- Stall duration is exactly N consecutive cycles; the stalled instruction issues in cycle N+1.
- Reset mid-stall: abort to RUN at the next edge; no residual stall.
- `branch_taken` in the same cycle as a new hazard: flush only, and the stall count is not incremented.
- `id_valid=0`: never stalls.

## Configuration
- `HAZARD_FORWARD_EN` defined (forwarding unit present):
  - N=1 when `ex_memread && ex_regwrite && m(ex_wreg)`.
  - Otherwise N=0; EX/MEM-stage producers are ignored.
- Undefined (no forwarding):
  - N=2 when `ex_regwrite && m(ex_wreg)`.
  - Otherwise N=1 when `mem_regwrite && m(mem_wreg)`.
  - Otherwise N=0.
  - The register file is write-first, so the WB stage never hazards.

## Test plan
- Reset: `rst=1` for 3 cycles → flush/bubble outputs 1, `pc_write=0`, counters 0. After release with no hazard → `pc_write=1`, `ifid_write=1`.
- Load-use with `HAZARD_FORWARD_EN`: ex_memread=1, ex_regwrite=1, ex_wreg=8, id_rs=8 → exactly 1 stall cycle, then normal; `stall_cycles=1`. Same case with ex_wreg=0 → no stall.
- No forwarding: ex_regwrite=1, ex_wreg=9, id_rt=9, id_uses_rt=1 → 2 stall cycles (RUN → STALL → RUN); with id_uses_rt=0 → no stall. mem_regwrite=1, mem_wreg=9 only → 1 stall cycle.
- `branch_taken` during the STALL cycle → that cycle drives all three flush outputs with `pc_write=1`, next cycle is RUN with normal outputs; `flush_count=1`, `stall_cycles` reflects only the first stall cycle.
- `rst` asserted in the STALL state → the next cycle after release is normal, not stalled.
- Saturation with STAT_W=2: 5 consecutive load-use hazards → `stall_cycles` holds at 3.
